// File: rtl/edge_pkg.sv
// Shared types and constants for the SRAM write-port arbiter.
package edge_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_STRIDE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Index width that stays legal when a count collapses to one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending requester after the last grant.
module rr_arbiter
    import edge_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned GNT_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [GNT_W-1:0]   last_i,
    output logic [GNT_W-1:0]   gnt_idx_c_o,
    output logic               gnt_valid_c_o
);

    always_comb begin
        int unsigned idx;
        idx           = 0;
        gnt_idx_c_o   = '0;
        gnt_valid_c_o = 1'b0;
        // Walk the ring starting just after the last winner.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_i) + k) % NUM_REQ;
            if (!gnt_valid_c_o && pending_i[GNT_W'(idx)]) begin
                gnt_valid_c_o = 1'b1;
                gnt_idx_c_o   = GNT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sram_write_arbiter.sv
// Shares one SRAM write port between NUM_REQ buffers: capture, round-robin
// grant, hold until ack, and sequential frame addressing.
module sram_write_arbiter
    import edge_pkg::*;
#(
    parameter int unsigned       NUM_REQ   = 2,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_WORDS = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_write_enable,
    input  logic [DATA_W*NUM_REQ-1:0] i_write_data,
    output logic [NUM_REQ-1:0]        o_write_complete,
    input  logic                      i_frame_start,
    output logic                      o_mem_write,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic                      i_mem_ack,
    output logic                      o_busy,
    output logic [NUM_REQ-1:0]        o_overrun,
    output logic                      o_frame_done
);

    localparam int unsigned       GNT_W     = idx_width(NUM_REQ);
    localparam int unsigned       CNT_W     = idx_width(NUM_WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [GNT_W-1:0]  PTR_RST   = GNT_W'(NUM_REQ - 1);

    arb_state_t          state_q,      state_d;
    logic [NUM_REQ-1:0]  pending_q,    pending_d;
    logic [DATA_W-1:0]   data_q [NUM_REQ];
    logic [DATA_W-1:0]   data_d [NUM_REQ];
    logic [GNT_W-1:0]    last_q,       last_d;
    logic [GNT_W-1:0]    grant_q,      grant_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                fs_pend_q,    fs_pend_d;
    logic                mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [NUM_REQ-1:0]  complete_q,   complete_d;
    logic [NUM_REQ-1:0]  overrun_q,    overrun_d;
    logic                busy_q,       busy_d;
    logic                frame_done_q, frame_done_d;

    logic [GNT_W-1:0]    pick_idx_c;
    logic                pick_valid_c;
    logic                ack_c;
    logic [NUM_REQ-1:0]  clear_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .pending_i     (pending_q),
        .last_i        (last_q),
        .gnt_idx_c_o   (pick_idx_c),
        .gnt_valid_c_o (pick_valid_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            data_q       <= '{default: '0};
            last_q       <= PTR_RST;
            grant_q      <= '0;
            addr_q       <= BASE_ADDR;
            cnt_q        <= '0;
            fs_pend_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            complete_q   <= '0;
            overrun_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            data_q       <= data_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            fs_pend_q    <= fs_pend_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            complete_q   <= complete_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        data_d       = data_q;
        last_d       = last_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        fs_pend_d    = fs_pend_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        complete_d   = '0;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        clear_c      = '0;
        ack_c        = (state_q == WRITE) && mem_write_q && i_mem_ack;

        // A new pulse arriving in the same cycle its predecessor completes is
        // accepted as fresh work rather than flagged.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            clear_c[i] = ack_c && (grant_q == GNT_W'(i));
            if (clear_c[i]) begin
                complete_d[i] = 1'b1;
                pending_d[i]  = 1'b0;
            end
            if (i_write_enable[i]) begin
                if (!pending_q[i] || clear_c[i]) begin
                    pending_d[i] = 1'b1;
                    data_d[i]    = i_write_data[DATA_W*i +: DATA_W];
                end else begin
                    overrun_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    addr_d    = BASE_ADDR;
                    cnt_d     = '0;
                    fs_pend_d = 1'b0;
                end
                if (pick_valid_c) begin
                    grant_d     = pick_idx_c;
                    last_d      = pick_idx_c;
                    mem_write_d = 1'b1;
                    mem_addr_d  = i_frame_start ? BASE_ADDR : addr_q;
                    mem_wdata_d = data_q[pick_idx_c];
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (i_frame_start) begin
                    fs_pend_d = 1'b1;
                end
                if (ack_c) begin
                    mem_write_d = 1'b0;
                    state_d     = RELEASE;
                    if (cnt_q == LAST_WORD) begin
                        addr_d       = BASE_ADDR;
                        cnt_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
                // A restart requested mid-transaction lands here, on entry to IDLE.
                if (fs_pend_q || i_frame_start) begin
                    addr_d    = BASE_ADDR;
                    cnt_d     = '0;
                    fs_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (|pending_d);
    end

    assign o_write_complete = complete_q;
    assign o_mem_write      = mem_write_q;
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_wdata      = mem_wdata_q;
    assign o_busy           = busy_q;
    assign o_overrun        = overrun_q;
    assign o_frame_done     = frame_done_q;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Directed bench for sram_write_arbiter; a second instance uses a 4-word frame.
module tb_sram_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [63:0] wdata;
    logic        fs;
    logic        ack;

    logic [1:0]  a_complete, a_overrun, b_complete, b_overrun;
    logic        a_mem_write, a_busy, a_fdone, b_mem_write, b_busy, b_fdone;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    sram_write_arbiter dut_a (
        .clk              (clk),
        .rst              (rst),
        .i_write_enable   (we),
        .i_write_data     (wdata),
        .o_write_complete (a_complete),
        .i_frame_start    (fs),
        .o_mem_write      (a_mem_write),
        .o_mem_addr       (a_addr),
        .o_mem_wdata      (a_wdata),
        .i_mem_ack        (ack),
        .o_busy           (a_busy),
        .o_overrun        (a_overrun),
        .o_frame_done     (a_fdone)
    );

    sram_write_arbiter #(.NUM_WORDS(4)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .i_write_enable   (we),
        .i_write_data     (wdata),
        .o_write_complete (b_complete),
        .i_frame_start    (fs),
        .o_mem_write      (b_mem_write),
        .o_mem_addr       (b_addr),
        .o_mem_wdata      (b_wdata),
        .i_mem_ack        (ack),
        .o_busy           (b_busy),
        .o_overrun        (b_overrun),
        .o_frame_done     (b_fdone)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1);
        we    = req;
        wdata = {d1, d0};
        tick();
        we    = 2'b00;
    endtask

    // Bounded wait for the strobe, then check what is on the bus.
    task automatic wait_issue(input string tag, input logic [15:0] exp_addr, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (!a_mem_write && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issued"}, 64'(a_mem_write), 64'd1);
        check({tag, "_addr"},   64'(a_addr),      64'(exp_addr));
        check({tag, "_wdata"},  64'(a_wdata),     64'(exp_data));
    endtask

    task automatic ack_write(input string tag, input int req, input bit fs_mid);
        if (fs_mid) begin
            fs = 1'b1;
            tick();
            fs = 1'b0;
            check({tag, "_held_mid"}, 64'(a_mem_write), 64'd1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_complete"}, 64'(a_complete),  64'd1 << req);
        check({tag, "_strobe_lo"}, 64'(a_mem_write), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; we = '0; wdata = '0; fs = 1'b0; ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_write",    64'(a_mem_write), 64'd0);
        check("rst_addr",     64'(a_addr),      64'd0);
        check("rst_wdata",    64'(a_wdata),     64'd0);
        check("rst_complete", 64'(a_complete),  64'd0);
        check("rst_busy",     64'(a_busy),      64'd0);
        check("rst_overrun",  64'(a_overrun),   64'd0);
        check("rst_fdone",    64'(a_fdone),     64'd0);

        // Single write: two-cycle issue latency, ack after three cycles.
        pulse(2'b01, 32'hA5A5_A5A5, 32'h0);
        check("t1_capture_no_write", 64'(a_mem_write), 64'd0);
        check("t1_busy",             64'(a_busy),      64'd1);
        tick();
        check("t1_write", 64'(a_mem_write), 64'd1);
        check("t1_addr",  64'(a_addr),      64'h0000);
        check("t1_wdata", 64'(a_wdata),     64'hA5A5_A5A5);
        tick();
        tick();
        check("t1_hold_write", 64'(a_mem_write), 64'd1);
        check("t1_hold_addr",  64'(a_addr),      64'h0000);
        ack_write("t1", 0, 1'b0);
        tick();
        check("t1_complete_one_cycle", 64'(a_complete), 64'd0);
        pulse(2'b01, 32'h5A5A_5A5A, 32'h0);
        wait_issue("t1_next", 16'h0004, 32'h5A5A_5A5A);
        ack_write("t1_next", 0, 1'b0);

        // Simultaneous pairs, round-robin order and address sequence.
        do_reset();
        pulse(2'b11, 32'h1111_1111, 32'h2222_2222);
        wait_issue("t2_r0", 16'h0000, 32'h1111_1111);
        ack_write("t2_r0", 0, 1'b0);
        tick();
        check("t2_gap", 64'(a_mem_write), 64'd0);
        tick();
        check("t2_gap_end", 64'(a_mem_write), 64'd1);
        wait_issue("t2_r1", 16'h0004, 32'h2222_2222);
        ack_write("t2_r1", 1, 1'b0);
        pulse(2'b11, 32'h3333_3333, 32'h4444_4444);
        wait_issue("t2_r0b", 16'h0008, 32'h3333_3333);
        ack_write("t2_r0b", 0, 1'b0);
        wait_issue("t2_r1b", 16'h000C, 32'h4444_4444);
        ack_write("t2_r1b", 1, 1'b0);

        // Overrun: second pulse while pending is dropped and flagged sticky.
        do_reset();
        pulse(2'b01, 32'hAAAA_0001, 32'h0);
        pulse(2'b01, 32'hBBBB_0002, 32'h0);
        check("t3_overrun_set", 64'(a_overrun), 64'd1);
        wait_issue("t3", 16'h0000, 32'hAAAA_0001);
        ack_write("t3", 0, 1'b0);
        repeat (5) tick();
        check("t3_no_second_write", 64'(a_mem_write), 64'd0);
        check("t3_idle_busy",       64'(a_busy),      64'd0);
        check("t3_overrun_sticky",  64'(a_overrun),   64'd1);

        // Frame restart requested mid-write takes effect after that write.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(2'b01, 32'(k), 32'h0);
            wait_issue("t4_fill", 16'(4 * k), 32'(k));
            ack_write("t4_fill", 0, 1'b0);
        end
        pulse(2'b01, 32'h0000_00F0, 32'h0);
        wait_issue("t4_cur", 16'h0010, 32'h0000_00F0);
        ack_write("t4_cur", 0, 1'b1);
        pulse(2'b01, 32'h0000_00F1, 32'h0);
        wait_issue("t4_restart", 16'h0000, 32'h0000_00F1);
        ack_write("t4_restart", 0, 1'b0);

        // Reset mid-write drops the transaction silently.
        pulse(2'b10, 32'h0, 32'hCAFE_0001);
        wait_issue("t5_pre", 16'h0004, 32'hCAFE_0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_write",    64'(a_mem_write), 64'd0);
        check("t5_addr",     64'(a_addr),      64'd0);
        check("t5_wdata",    64'(a_wdata),     64'd0);
        check("t5_complete", 64'(a_complete),  64'd0);
        check("t5_busy",     64'(a_busy),      64'd0);
        tick();
        check("t5_no_complete", 64'(a_complete),  64'd0);
        check("t5_no_reissue",  64'(a_mem_write), 64'd0);
        pulse(2'b01, 32'hD00D_0001, 32'h0);
        wait_issue("t5_fresh", 16'h0000, 32'hD00D_0001);
        ack_write("t5_fresh", 0, 1'b0);

        // Four-word frame: done pulses after the fourth ack, fifth write wraps.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pulse(2'b01, 32'h100 + 32'(k), 32'h0);
            wait_issue("t6", 16'(4 * k), 32'h100 + 32'(k));
            check("t6_b_addr", 64'(b_addr), (k == 4) ? 64'd0 : 64'(4 * k));
            ack_write("t6", 0, 1'b0);
            check("t6_b_complete", 64'(b_complete), 64'd1);
            check("t6_b_fdone",    64'(b_fdone),    (k == 3) ? 64'd1 : 64'd0);
            check("t6_a_fdone",    64'(a_fdone),    64'd0);
        end
        tick();
        check("t6_b_fdone_one_cycle", 64'(b_fdone),   64'd0);
        check("t6_b_overrun",         64'(b_overrun), 64'd0);
        check("t6_b_wdata",           64'(b_wdata),   64'h104);
        tick();
        check("t6_b_busy",            64'(b_busy),    64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
